// File: rtl/hid_inject_sched.sv
// Keystroke injection scheduler: queues {mod,code} and claims two host polls per key (press, then release).
// Latency: owned/own_data assert the cycle after the poll pulse; a FIFO pop lands the cycle after the release ack.
// Backpressure: key_ready drops when the queue is full; no combinational path from key_valid to key_ready.
module hid_inject_sched #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 256,
    parameter int MAX_RETRY   = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          key_valid,
    input  logic [7:0]                    key_mod,
    input  logic [7:0]                    key_code,
    output logic                          key_ready,
    input  logic                          inj_en,
    input  logic                          poll,
    input  logic                          pkt_done,
    input  logic                          ack,
    output logic [63:0]                   own_data,
    output logic                          owned,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    drop_cnt,
    output logic [2:0]                    state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS_ARM = 3'd1,
        PRESS_TX  = 3'd2,
        PRESS_ACK = 3'd3,
        REL_ARM   = 3'd4,
        REL_TX    = 3'd5,
        REL_ACK   = 3'd6
    } state_t;

    typedef struct packed {
        logic [7:0] mod;
        logic [7:0] code;
    } key_t;

    key_t            mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_q;
    logic            push, pop;
    key_t            head;

    state_t          state_q, state_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      drop_q;
    logic            drop_inc;
    logic            owned_q, owned_d;
    logic [63:0]     own_data_q, own_data_d;
    logic            timeout, retry_left, in_ack;

    assign key_ready  = (count_q < CW'(FIFO_DEPTH));
    assign push       = key_valid & key_ready;
    assign head       = mem[rd_ptr];
    assign fifo_count = count_q;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{mod: key_mod, code: key_code};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // State register plus the per-report retry/timer bookkeeping and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            retry_q    <= '0;
            timer_q    <= '0;
            drop_q     <= '0;
            owned_q    <= 1'b0;
            own_data_q <= '0;
        end else begin
            state_q    <= state_d;
            retry_q    <= retry_d;
            timer_q    <= timer_d;
            owned_q    <= owned_d;
            own_data_q <= own_data_d;
            if (drop_inc && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    assign timeout    = (timer_q == TW'(ACK_TIMEOUT - 1));
    assign retry_left = (retry_q < RW'(MAX_RETRY));
    assign in_ack     = (state_q == PRESS_ACK) || (state_q == REL_ACK);

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        pop      = 1'b0;
        drop_inc = 1'b0;
        case (state_q)
            IDLE: if (count_q != '0 && inj_en) begin
                state_d = PRESS_ARM;
                retry_d = '0;
            end
            PRESS_ARM: if (poll)     state_d = PRESS_TX;
            PRESS_TX:  if (pkt_done) state_d = PRESS_ACK;
            PRESS_ACK: begin
                // ack beats a coincident timeout or early poll
                if (ack) begin
                    state_d = REL_ARM;
                    retry_d = '0;
                end else if (timeout || poll) begin
                    if (retry_left) begin
                        state_d = PRESS_ARM;
                        retry_d = retry_q + RW'(1);
                    end else begin
                        state_d = REL_ARM;
                        retry_d = '0;
                    end
                end
            end
            REL_ARM: if (poll)     state_d = REL_TX;
            REL_TX:  if (pkt_done) state_d = REL_ACK;
            REL_ACK: begin
                if (ack) begin
                    state_d = IDLE;
                    pop     = 1'b1;
                end else if (timeout || poll) begin
                    if (retry_left) begin
                        state_d = REL_ARM;
                        retry_d = retry_q + RW'(1);
                    end else begin
                        state_d  = IDLE;
                        pop      = 1'b1;
                        drop_inc = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        timer_d = (in_ack && state_d == state_q) ? timer_q + TW'(1) : '0;
    end

    always_comb begin
        owned_d    = (state_d == PRESS_TX) || (state_d == REL_TX);
        own_data_d = '0;
        if (state_d == PRESS_TX) own_data_d = {40'h0, head.code, 8'h00, head.mod};
    end

    assign owned    = owned_q;
    assign own_data = own_data_q;
    assign busy     = (state_q != IDLE);
    assign drop_cnt = drop_q;
    assign state    = state_q;

endmodule

// File: tb/tb_hid_inject_sched.sv
// Directed bench for hid_inject_sched: basic keystroke, full queue, enable gating, push+pop, retries, async reset.
module tb_hid_inject_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [7:0]  key_mod, key_code;
    logic        key_ready;
    logic        inj_en, poll, pkt_done, ack;
    logic [63:0] own_data;
    logic        owned, busy;
    logic [2:0]  fifo_count;
    logic [7:0]  drop_cnt;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hid_inject_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_mod    (key_mod),
        .key_code   (key_code),
        .key_ready  (key_ready),
        .inj_en     (inj_en),
        .poll       (poll),
        .pkt_done   (pkt_done),
        .ack        (ack),
        .own_data   (own_data),
        .owned      (owned),
        .busy       (busy),
        .fifo_count (fifo_count),
        .drop_cnt   (drop_cnt),
        .state      (state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_poll();
        poll = 1'b1; ticks(1); poll = 1'b0;
    endtask

    task automatic pulse_done();
        pkt_done = 1'b1; ticks(1); pkt_done = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1; ticks(1); ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; key_valid = 1'b0; key_mod = '0; key_code = '0;
        inj_en = 1'b0; poll = 1'b0; pkt_done = 1'b0; ack = 1'b0;
        ticks(2);
        check("rst_owned", owned, 0);
        check("rst_own_data", own_data, 0);
        check("rst_key_ready", key_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_state", state, 0);
        rst_n = 1'b1;
        ticks(1);

        // Basic keystroke
        inj_en = 1'b1;
        key_valid = 1'b1; key_mod = 8'h02; key_code = 8'h04;
        ticks(1);
        key_valid = 1'b0;
        check("basic_count", fifo_count, 1);
        ticks(1);
        check("basic_arm", state, 1);
        pulse_poll();
        check("basic_owned_p1", owned, 1);
        check("basic_press_data", own_data, 64'h0000_0000_0004_0002);
        ticks(19);
        pkt_done = 1'b1;
        check("basic_owned_at_done", owned, 1);
        check("basic_data_at_done", own_data, 64'h0000_0000_0004_0002);
        ticks(1); pkt_done = 1'b0;
        check("basic_owned_after_done", owned, 0);
        check("basic_data_after_done", own_data, 0);
        check("basic_press_ack_state", state, 3);
        ticks(9);
        pulse_ack();
        check("basic_rel_arm", state, 4);
        pulse_poll();
        check("basic_rel_owned", owned, 1);
        check("basic_rel_data", own_data, 0);
        pulse_done();
        pulse_ack();
        check("basic_final_count", fifo_count, 0);
        check("basic_final_state", state, 0);

        // Queue full, with injection disabled
        inj_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            key_valid = 1'b1; key_mod = 8'h01 + 8'(i); key_code = 8'h10 + 8'(i);
            ticks(1);
            if (i == 3) begin
                check("full_key_ready", key_ready, 0);
                check("full_count4", fifo_count, 4);
            end
        end
        key_valid = 1'b0;
        check("full_count_after5", fifo_count, 4);

        // Enable gating: polls with inj_en low are ignored
        pulse_poll();
        check("gate_owned", owned, 0);
        check("gate_state", state, 0);
        ticks(3);
        inj_en = 1'b1;
        ticks(1);
        check("gate_arm", state, 1);
        pulse_poll();
        check("gate_press_data", own_data, 64'h0000_0000_0010_0001);
        pulse_done();
        inj_en = 1'b0;
        ticks(2);
        pulse_ack();
        pulse_poll();
        check("gate_rel_owned", owned, 1);
        check("gate_rel_data", own_data, 0);
        pulse_done();
        pulse_ack();
        check("gate_count", fifo_count, 3);
        ticks(5);
        check("gate_stays_idle", state, 0);

        // Simultaneous push and pop
        inj_en = 1'b1;
        ticks(1);
        pulse_poll();
        check("pp_press_data", own_data, 64'h0000_0000_0011_0002);
        pulse_done();
        pulse_ack();
        pulse_poll();
        pulse_done();
        key_valid = 1'b1; key_mod = 8'h07; key_code = 8'h30;
        ack = 1'b1;
        ticks(1);
        ack = 1'b0; key_valid = 1'b0;
        check("pp_count", fifo_count, 3);

        // Retry path: nothing acked
        ticks(1);
        for (int a = 0; a < 4; a++) begin
            pulse_poll();
            check("retry_press_owned", owned, 1);
            check("retry_press_data", own_data, 64'h0000_0000_0012_0003);
            pulse_done();
            ticks(255);
            check("retry_press_wait", state, 3);
            ticks(1);
            check("retry_press_next", state, (a < 3) ? 64'd1 : 64'd4);
        end
        for (int a = 0; a < 4; a++) begin
            pulse_poll();
            check("retry_rel_owned", owned, 1);
            check("retry_rel_data", own_data, 0);
            pulse_done();
            ticks(255);
            check("retry_rel_wait", state, 6);
            ticks(1);
            check("retry_rel_next", state, (a < 3) ? 64'd4 : 64'd0);
        end
        check("retry_drop_cnt", drop_cnt, 1);
        check("retry_count", fifo_count, 2);

        // Async reset while in PRESS_TX
        ticks(1);
        pulse_poll();
        check("arst_pre_state", state, 2);
        check("arst_pre_data", own_data, 64'h0000_0000_0013_0004);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_owned", owned, 0);
        check("arst_own_data", own_data, 0);
        check("arst_count", fifo_count, 0);
        check("arst_state", state, 0);
        ticks(1);
        rst_n = 1'b1;
        ticks(1);
        key_valid = 1'b1; key_mod = 8'h00; key_code = 8'h05;
        ticks(1);
        key_valid = 1'b0;
        ticks(1);
        pulse_poll();
        check("resume_press_data", own_data, 64'h0000_0000_0005_0000);
        pulse_done();
        pulse_ack();
        pulse_poll();
        pulse_done();
        pulse_ack();
        check("resume_count", fifo_count, 0);
        check("resume_state", state, 0);
        check("resume_drop_cnt", drop_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
